// File: rtl/pacman_move_ctrl.sv
// Per-frame Pac-Man movement sequencer: samples the requested direction on each
// frame tick, checks candidate positions with the wall checker, then commits the new pose.
module pacman_move_ctrl #(
    parameter logic [9:0] X_INIT      = 10'd305,
    parameter logic [9:0] Y_INIT      = 10'd345,
    parameter int         STEP        = 2,
    parameter logic [9:0] X_MIN       = 10'd144,
    parameter logic [9:0] X_MAX       = 10'd754,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_tick,
    input  logic [3:0] i_dir_req,
    output logic       o_wall_req,
    output logic [9:0] o_wall_x,
    output logic [9:0] o_wall_y,
    input  logic       i_wall_ack,
    input  logic       i_wall_hit,
    output logic [9:0] o_pm_xpos,
    output logic [9:0] o_pm_ypos,
    output logic [3:0] o_pm_direction,
    output logic       o_moving,
    output logic       o_tick_overrun
);

    localparam logic [9:0]       STEP_W    = 10'(STEP);
    localparam int               CNT_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(ACK_TIMEOUT);

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TURN_Q,
        S_FWD_Q,
        S_COMMIT
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_req_q;
    logic             r_wall_req;
    logic [9:0]       r_wall_x;
    logic [9:0]       r_wall_y;
    logic [9:0]       r_pm_x;
    logic [9:0]       r_pm_y;
    logic [3:0]       r_pm_dir;
    logic             r_moving;
    logic             r_overrun;
    logic [9:0]       r_new_x;
    logic [9:0]       r_new_y;
    logic [3:0]       r_new_dir;
    logic             r_new_moving;

    logic [19:0] w_req_cand;
    logic [19:0] w_fwd_cand;
    logic        w_req_valid;
    logic        w_take_turn;
    logic        w_timeout;

    // Candidate {x, y} one step in direction d; x wraps through the side tunnel.
    function automatic logic [19:0] cand(input logic [3:0] d, input logic [9:0] x, input logic [9:0] y);
        logic [9:0]  cx;
        logic [9:0]  cy;
        logic [10:0] xs;
        cx = x;
        cy = y;
        xs = {1'b0, x} + {1'b0, STEP_W};
        case (d)
            DIR_RIGHT: cx = (xs > {1'b0, X_MAX}) ? X_MIN : xs[9:0];
            DIR_LEFT:  cx = (x < X_MIN + STEP_W) ? X_MAX : x - STEP_W;
            DIR_UP:    cy = y - STEP_W;
            DIR_DOWN:  cy = y + STEP_W;
            default:   ;
        endcase
        return {cx, cy};
    endfunction

    assign w_req_cand  = cand(i_dir_req, r_pm_x, r_pm_y);
    assign w_fwd_cand  = cand(r_pm_dir, r_pm_x, r_pm_y);
    assign w_req_valid = (i_dir_req != 4'b0000) && ((i_dir_req & (i_dir_req - 4'd1)) == 4'b0000);
    assign w_take_turn = w_req_valid && (i_dir_req != r_pm_dir);
    assign w_timeout   = (r_cnt == TIMEOUT_W);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_req_q      <= 4'b0000;
            r_wall_req   <= 1'b0;
            r_wall_x     <= 10'd0;
            r_wall_y     <= 10'd0;
            r_pm_x       <= X_INIT;
            r_pm_y       <= Y_INIT;
            r_pm_dir     <= DIR_LEFT;
            r_moving     <= 1'b0;
            r_overrun    <= 1'b0;
            r_new_x      <= X_INIT;
            r_new_y      <= Y_INIT;
            r_new_dir    <= DIR_LEFT;
            r_new_moving <= 1'b0;
        end else begin
            // Ticks outside IDLE are dropped, including the one landing on COMMIT.
            if (i_frame_tick && (r_state != S_IDLE))
                r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (i_frame_tick) begin
                        r_req_q    <= i_dir_req;
                        r_cnt      <= '0;
                        r_wall_req <= 1'b1;
                        if (w_take_turn) begin
                            r_state  <= S_TURN_Q;
                            r_wall_x <= w_req_cand[19:10];
                            r_wall_y <= w_req_cand[9:0];
                        end else begin
                            r_state  <= S_FWD_Q;
                            r_wall_x <= w_fwd_cand[19:10];
                            r_wall_y <= w_fwd_cand[9:0];
                        end
                    end
                end

                S_TURN_Q: begin
                    if (i_wall_ack && !i_wall_hit) begin
                        r_state      <= S_COMMIT;
                        r_wall_req   <= 1'b0;
                        r_new_x      <= r_wall_x;
                        r_new_y      <= r_wall_y;
                        r_new_dir    <= r_req_q;
                        r_new_moving <= 1'b1;
                    end else if (i_wall_ack || w_timeout) begin
                        // Blocked turn falls straight through to the forward query; req stays up.
                        r_state  <= S_FWD_Q;
                        r_cnt    <= '0;
                        r_wall_x <= w_fwd_cand[19:10];
                        r_wall_y <= w_fwd_cand[9:0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_FWD_Q: begin
                    if (i_wall_ack && !i_wall_hit) begin
                        r_state      <= S_COMMIT;
                        r_wall_req   <= 1'b0;
                        r_new_x      <= r_wall_x;
                        r_new_y      <= r_wall_y;
                        r_new_dir    <= r_pm_dir;
                        r_new_moving <= 1'b1;
                    end else if (i_wall_ack || w_timeout) begin
                        r_state      <= S_COMMIT;
                        r_wall_req   <= 1'b0;
                        r_new_x      <= r_pm_x;
                        r_new_y      <= r_pm_y;
                        r_new_dir    <= r_pm_dir;
                        r_new_moving <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_COMMIT: begin
                    r_pm_x   <= r_new_x;
                    r_pm_y   <= r_new_y;
                    r_pm_dir <= r_new_dir;
                    r_moving <= r_new_moving;
                    r_state  <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_wall_req     = r_wall_req;
    assign o_wall_x       = r_wall_x;
    assign o_wall_y       = r_wall_y;
    assign o_pm_xpos      = r_pm_x;
    assign o_pm_ypos      = r_pm_y;
    assign o_pm_direction = r_pm_dir;
    assign o_moving       = r_moving;
    assign o_tick_overrun = r_overrun;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl: hand-computed positions for moves, turns,
// tunnel wrap, wall hits, ack timeout and tick overrun.
module tb_pacman_move_ctrl;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic [3:0] dir_req;
    logic       wall_req;
    logic [9:0] wall_x;
    logic [9:0] wall_y;
    logic       wall_ack;
    logic       wall_hit;
    logic [9:0] pm_xpos;
    logic [9:0] pm_ypos;
    logic [3:0] pm_direction;
    logic       moving;
    logic       tick_overrun;

    int n_tests;
    int n_failed;

    pacman_move_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_frame_tick   (frame_tick),
        .i_dir_req      (dir_req),
        .o_wall_req     (wall_req),
        .o_wall_x       (wall_x),
        .o_wall_y       (wall_y),
        .i_wall_ack     (wall_ack),
        .i_wall_hit     (wall_hit),
        .o_pm_xpos      (pm_xpos),
        .o_pm_ypos      (pm_ypos),
        .o_pm_direction (pm_direction),
        .o_moving       (moving),
        .o_tick_overrun (tick_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    // Tick is sampled on the posedge between the two negedges; returns in the first query cycle.
    task automatic drive_tick(input logic [3:0] d);
        @(negedge clk);
        frame_tick = 1'b1;
        dir_req    = d;
        @(negedge clk);
        frame_tick = 1'b0;
        dir_req    = 4'b0000;
    endtask

    task automatic send_ack(input int waits, input logic hit);
        repeat (waits) @(negedge clk);
        wall_ack = 1'b1;
        wall_hit = hit;
        @(negedge clk);
        wall_ack = 1'b0;
        wall_hit = 1'b0;
    endtask

    task automatic move(input logic [3:0] d, input logic hit);
        drive_tick(d);
        send_ack(0, hit);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int req_cycles;
        n_tests    = 0;
        n_failed   = 0;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        dir_req    = 4'b0000;
        wall_ack   = 1'b0;
        wall_hit   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_x", pm_xpos, 305);
        check("rst_y", pm_ypos, 345);
        check("rst_dir", pm_direction, 4'b0010);
        check("rst_req", wall_req, 0);
        check("rst_wx", wall_x, 0);
        check("rst_wy", wall_y, 0);
        check("rst_moving", moving, 0);
        check("rst_ovr", tick_overrun, 0);
        rst_n = 1'b1;

        // Reset mid-query, with an overrun pending
        drive_tick(4'b0000);
        check("mq_req", wall_req, 1);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("mq_ovr_set", tick_overrun, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mq_req_clr", wall_req, 0);
        check("mq_x", pm_xpos, 305);
        check("mq_y", pm_ypos, 345);
        check("mq_dir", pm_direction, 4'b0010);
        check("mq_ovr_clr", tick_overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight move, ack 3 cycles late
        drive_tick(4'b0000);
        check("st_req", wall_req, 1);
        check("st_wx", wall_x, 303);
        check("st_wy", wall_y, 345);
        send_ack(3, 1'b0);
        check("st_req_drop", wall_req, 0);
        check("st_x_pre", pm_xpos, 305);
        @(negedge clk);
        check("st_x", pm_xpos, 303);
        check("st_moving", moving, 1);
        check("st_dir", pm_direction, 4'b0010);
        wall_ack = 1'b1;
        @(negedge clk);
        wall_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_ack_req", wall_req, 0);
        check("stray_ack_x", pm_xpos, 303);

        // Buffered turn blocked, forward move taken
        do_reset();
        drive_tick(4'b0100);
        check("tb_turn_wx", wall_x, 305);
        check("tb_turn_wy", wall_y, 343);
        send_ack(0, 1'b1);
        check("tb_fwd_req", wall_req, 1);
        check("tb_fwd_wx", wall_x, 303);
        check("tb_fwd_wy", wall_y, 345);
        send_ack(0, 1'b0);
        @(negedge clk);
        check("tb_x", pm_xpos, 303);
        check("tb_y", pm_ypos, 345);
        check("tb_dir", pm_direction, 4'b0010);

        // Turn taken: single query
        drive_tick(4'b1000);
        check("tt_wx", wall_x, 303);
        check("tt_wy", wall_y, 347);
        send_ack(0, 1'b0);
        check("tt_req_drop", wall_req, 0);
        @(negedge clk);
        check("tt_y", pm_ypos, 347);
        check("tt_dir", pm_direction, 4'b1000);
        check("tt_x", pm_xpos, 303);
        @(negedge clk);
        check("tt_one_query", wall_req, 0);

        // Walk left to x=145, then wrap through the tunnel both ways
        move(4'b0010, 1'b0);
        check("wl_x", pm_xpos, 301);
        for (int i = 0; i < 78; i++) move(4'b0000, 1'b0);
        check("wl_x145", pm_xpos, 145);
        drive_tick(4'b0000);
        check("wrapl_wx", wall_x, 754);
        send_ack(0, 1'b0);
        @(negedge clk);
        check("wrapl_x", pm_xpos, 754);
        drive_tick(4'b0001);
        check("wrapr_wx", wall_x, 144);
        send_ack(0, 1'b0);
        @(negedge clk);
        check("wrapr_x", pm_xpos, 144);
        check("wrapr_dir", pm_direction, 4'b0001);

        // Forward blocked: no move, moving=0
        drive_tick(4'b0000);
        check("blk_wx", wall_x, 146);
        send_ack(0, 1'b1);
        @(negedge clk);
        check("blk_x", pm_xpos, 144);
        check("blk_moving", moving, 0);

        // Non-one-hot request behaves as no request
        drive_tick(4'b0011);
        check("noh_wx", wall_x, 146);
        check("noh_wy", wall_y, 347);
        send_ack(0, 1'b0);
        @(negedge clk);
        check("noh_x", pm_xpos, 146);
        check("noh_dir", pm_direction, 4'b0001);
        check("noh_moving", moving, 1);

        // Timeout on both queries, with an overrun tick at cycle 5
        check("to_ovr0", tick_overrun, 0);
        @(negedge clk);
        frame_tick = 1'b1;
        dir_req    = 4'b0100;
        req_cycles = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                frame_tick = 1'b0;
                dir_req    = 4'b0000;
                check("to_turn_wx", wall_x, 146);
                check("to_turn_wy", wall_y, 345);
            end
            if (n == 5) frame_tick = 1'b1;
            if (n == 6) begin
                frame_tick = 1'b0;
                check("to_ovr_set", tick_overrun, 1);
            end
            if (n == 16) check("to_turn_last_wy", wall_y, 345);
            if (n == 17) begin
                check("to_fwd_wx", wall_x, 148);
                check("to_fwd_wy", wall_y, 347);
            end
            if (n == 33) check("to_moving_pre", moving, 1);
            if (n == 34) begin
                check("to_moving", moving, 0);
                check("to_x", pm_xpos, 146);
                check("to_y", pm_ypos, 347);
                check("to_dir", pm_direction, 4'b0001);
            end
            if (wall_req) req_cycles++;
        end
        check("to_req_cycles", req_cycles, 32);
        check("to_req_idle", wall_req, 0);
        check("to_ovr_sticky", tick_overrun, 1);

        // Tick coinciding with COMMIT is an overrun and is dropped
        do_reset();
        check("cm_ovr0", tick_overrun, 0);
        drive_tick(4'b0000);
        send_ack(0, 1'b0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("cm_ovr", tick_overrun, 1);
        check("cm_x", pm_xpos, 303);
        @(negedge clk);
        check("cm_dropped", wall_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
